// File: rtl/sar_multichannel_sequencer.sv
// rtl/sar_multichannel_sequencer.sv - multi-channel SAR ADC sequencer with oversampling and result stream
// Scans masked channels in ascending order, runs the SAR search from the comparator and averages 2^k results.
module sar_multichannel_sequencer #(
    parameter int N_BITS        = 10,
    parameter int N_CHANNELS    = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int MAX_AVG_LOG2  = 3,
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int AVG_W = $clog2(MAX_AVG_LOG2 + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [N_CHANNELS-1:0] channel_mask,
    input  logic [AVG_W-1:0]      avg_log2,
    input  logic                  comparator_in,
    output logic                  busy,
    output logic [CH_W-1:0]       channel_select,
    output logic                  hold,
    output logic [N_BITS-1:0]     dac_code,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [N_BITS-1:0]     result_data,
    output logic [CH_W-1:0]       result_channel,
    output logic                  eoc
);
    localparam int ACC_W = N_BITS + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_OUTPUT, S_NEXT} state_t;

    state_t                state_q, state_d;
    logic [N_CHANNELS-1:0] mask_q, mask_d;
    logic [AVG_W-1:0]      avg_q, avg_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [SMP_W-1:0]      samp_q, samp_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [N_BITS-1:0]     kept_q, kept_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_BITS-1:0]     res_data_q, res_data_d;
    logic [CH_W-1:0]       res_ch_q, res_ch_d;
    logic                  valid_q, valid_d;

    logic [N_BITS-1:0] trial, kept_next;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CH_W:0]     start_first, mask_first, mask_higher;

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [CH_W:0] lowest_from(input logic [N_CHANNELS-1:0] m, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        avg_d      = avg_q;
        chan_d     = chan_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        kept_d     = kept_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_ch_d   = res_ch_q;
        hold       = 1'b0;
        dac_code   = '0;
        eoc        = 1'b0;

        trial       = kept_q | (N_BITS'(1) << bit_q);
        kept_next   = comparator_in ? trial : kept_q;
        sum         = acc_q + ACC_W'(kept_next);
        cnt_inc     = cnt_q + CNT_W'(1);
        start_first = lowest_from(channel_mask, 0);
        mask_first  = lowest_from(mask_q, 0);
        mask_higher = lowest_from(mask_q, int'(chan_q) + 1);

        case (state_q)
            S_IDLE: begin
                if (start && start_first[CH_W]) begin
                    mask_d  = channel_mask;
                    avg_d   = (int'(avg_log2) > MAX_AVG_LOG2) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
                    chan_d  = start_first[CH_W-1:0];
                    samp_d  = '0;
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (samp_q == SMP_W'(SAMPLE_CYCLES - 1)) begin
                    bit_d   = BIT_W'(N_BITS - 1);
                    kept_d  = '0;
                    state_d = S_CONVERT;
                end else begin
                    samp_d = samp_q + SMP_W'(1);
                end
            end
            S_CONVERT: begin
                hold     = 1'b1;
                dac_code = trial;
                kept_d   = kept_next;
                if (bit_q == '0) begin
                    samp_d = '0;
                    if (cnt_inc < (CNT_W'(1) << avg_q)) begin
                        acc_d   = sum;
                        cnt_d   = cnt_inc;
                        state_d = S_SAMPLE;
                    end else begin
                        res_data_d = N_BITS'(sum >> avg_q);
                        res_ch_d   = chan_q;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = S_OUTPUT;
                    end
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (valid_q && result_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                samp_d = '0;
                if (mask_higher[CH_W]) begin
                    chan_d  = mask_higher[CH_W-1:0];
                    state_d = S_SAMPLE;
                end else begin
                    eoc = 1'b1;
                    if (continuous && mask_first[CH_W]) begin
                        chan_d  = mask_first[CH_W-1:0];
                        state_d = S_SAMPLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid follows entry into OUTPUT by one cycle and drops right after the handshake.
    assign valid_d = (state_q == S_OUTPUT) && !(valid_q && result_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            avg_q      <= '0;
            chan_q     <= '0;
            samp_q     <= '0;
            bit_q      <= '0;
            kept_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_ch_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            avg_q      <= avg_d;
            chan_q     <= chan_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            kept_q     <= kept_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_ch_q   <= res_ch_d;
            valid_q    <= valid_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign channel_select = chan_q;
    assign result_valid   = valid_q;
    assign result_data    = res_data_q;
    assign result_channel = res_ch_q;
endmodule

// File: tb/tb_sar_multichannel_sequencer.sv
// tb/tb_sar_multichannel_sequencer.sv - scoreboard bench for sar_multichannel_sequencer
module tb_sar_multichannel_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       continuous;
    logic [3:0] channel_mask;
    logic [1:0] avg_log2;
    logic       comparator_in;
    logic       busy;
    logic [1:0] channel_select;
    logic       hold;
    logic [9:0] dac_code;
    logic       result_valid;
    logic       result_ready;
    logic [9:0] result_data;
    logic [1:0] result_channel;
    logic       eoc;

    sar_multichannel_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .channel_mask(channel_mask), .avg_log2(avg_log2), .comparator_in(comparator_in),
        .busy(busy), .channel_select(channel_select), .hold(hold), .dac_code(dac_code),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .result_channel(result_channel), .eoc(eoc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Analog model: ideal comparator against a per-channel voltage or a per-conversion table.
    logic [9:0] vin_ch [4];
    logic [9:0] avg_tab [4];
    logic       avg_mode = 1'b0;
    int         conv_idx = 0;
    int         passes   = 0;
    logic [9:0] cur_vin;
    always_comb begin
        cur_vin = avg_mode ? avg_tab[conv_idx] : vin_ch[channel_select];
    end
    assign comparator_in = (cur_vin >= dac_code);

    always @(posedge hold) passes++;
    always @(negedge hold) if (conv_idx < 3) conv_idx++;

    // Scoreboard: expected {channel, data} pushed at stimulus, popped on handshake.
    logic [11:0] sb[$];
    int          eoc_cnt = 0;
    logic [3:0]  seen_ch = '0;
    logic        watch   = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    logic [11:0] e;
                    e = sb.pop_front();
                    chk("res_ch", 32'(result_channel), 32'(e[11:10]));
                    chk("res_data", 32'(result_data), 32'(e[9:0]));
                end
            end
            if (eoc) eoc_cnt++;
            if (watch && busy) seen_ch[channel_select] = 1'b1;
        end
    end

    task automatic do_start(input logic [3:0] m, input logic [1:0] a);
        @(negedge clk);
        channel_mask = m;
        avg_log2     = a;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    initial begin
        int          lat;
        int          e0;
        int          n;
        logic        stable;
        logic [9:0]  cap_d;
        logic [1:0]  cap_c;

        reset = 1'b0; start = 1'b0; continuous = 1'b0; channel_mask = '0; avg_log2 = '0;
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) vin_ch[i] = '0;
        avg_tab[0] = 10'd100; avg_tab[1] = 10'd101; avg_tab[2] = 10'd102; avg_tab[3] = 10'd104;
        #12;
        chk("rst_outs", {busy, hold, result_valid, eoc, channel_select, result_channel},
            32'd0);
        chk("rst_dac", 32'(dac_code), 0);
        chk("rst_data", 32'(result_data), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: single channel latency and eoc/busy timing
        vin_ch[0] = 10'h2A5;
        @(negedge clk);
        channel_mask = 4'b0001; avg_log2 = 2'd0; start = 1'b1;
        sb.push_back({2'd0, 10'h2A5});
        @(posedge clk); #1;
        start = 1'b0;
        chk("t1_busy_rise", 32'(busy), 1);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t1_latency", lat, 13);
        @(posedge clk); #1;
        chk("t1_eoc", 32'(eoc), 1);
        chk("t1_valid_drop", 32'(result_valid), 0);
        @(posedge clk); #1;
        chk("t1_busy_fall", 32'(busy), 0);
        chk("t1_eoc_pulse", 32'(eoc), 0);

        // 2: sparse mask, extreme codes
        vin_ch[1] = 10'h3FF; vin_ch[3] = 10'h000;
        seen_ch = '0; watch = 1'b1; e0 = eoc_cnt;
        sb.push_back({2'd1, 10'h3FF});
        sb.push_back({2'd3, 10'h000});
        do_start(4'b1010, 2'd0);
        wait_idle(300);
        watch = 1'b0;
        chk("t2_no_ch0_ch2", 32'({seen_ch[0], seen_ch[2]}), 0);
        chk("t2_eoc_count", eoc_cnt - e0, 1);
        chk("t2_sb_empty", sb.size(), 0);

        // 3: 4x oversampling, truncated mean of 100,101,102,104
        avg_mode = 1'b1; conv_idx = 0; passes = 0;
        sb.push_back({2'd0, 10'd101});
        do_start(4'b0001, 2'd2);
        wait_idle(300);
        avg_mode = 1'b0;
        chk("t3_passes", passes, 4);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: back-pressure holds the result stable and freezes the converter
        vin_ch[2] = 10'h1C3;
        result_ready = 1'b0;
        sb.push_back({2'd2, 10'h1C3});
        do_start(4'b0100, 2'd0);
        n = 0;
        while (!result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_seen", 32'(result_valid), 1);
        cap_d = result_data; cap_c = result_channel; stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!result_valid || result_data != cap_d || result_channel != cap_c ||
                hold || dac_code != 10'd0) stable = 1'b0;
        end
        chk("t4_stall_stable", 32'(stable), 1);
        chk("t4_stall_data", 32'(cap_d), 32'h1C3);
        result_ready = 1'b1;
        wait_idle(20);
        chk("t4_sb_empty", sb.size(), 0);

        // 5: continuous scan, then drop continuous during the third scan
        vin_ch[0] = 10'h155; vin_ch[1] = 10'h0AA;
        continuous = 1'b1; e0 = eoc_cnt;
        repeat (3) begin
            sb.push_back({2'd0, 10'h155});
            sb.push_back({2'd1, 10'h0AA});
        end
        do_start(4'b0011, 2'd0);
        n = 0;
        while (eoc_cnt - e0 < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_two_scans", eoc_cnt - e0, 2);
        repeat (5) @(negedge clk);
        continuous = 1'b0;
        wait_idle(300);
        chk("t5_eoc_count", eoc_cnt - e0, 3);
        chk("t5_sb_empty", sb.size(), 0);

        // 6: reset abort, empty-mask start, start while busy
        vin_ch[0] = 10'h2A5; e0 = eoc_cnt;
        do_start(4'b0001, 2'd0);
        n = 0;
        while (!hold && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_ctrl", {busy, hold, result_valid, eoc, channel_select, result_channel},
            32'd0);
        chk("t6_rst_dac", 32'(dac_code), 0);
        @(negedge clk);
        reset = 1'b1;
        do_start(4'b0000, 2'd0);
        @(negedge clk);
        chk("t6_mask0_ignored", 32'(busy), 0);
        sb.push_back({2'd0, 10'h2A5});
        do_start(4'b0001, 2'd0);
        do_start(4'b1000, 2'd0);
        wait_idle(100);
        repeat (3) @(negedge clk);
        chk("t6_no_restart", 32'(busy), 0);
        chk("t6_eoc_count", eoc_cnt - e0, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
